// File: rtl/segment_transition_ctrl.sv
// Segment transition controller: queues a segment switch behind a sync, time or GPIO trigger
// and tracks the repeat budget of the active segment. Optional GPIO mode: SEGMENT_TRANSITION_GPIO_EN.
module segment_transition_ctrl #(
  parameter int NUM_SEGMENTS   = 2,
  parameter int REP_WIDTH      = 16,
  parameter int SYS_TIME_WIDTH = 56,
  parameter int NUM_GPIO       = 4,
  localparam int SEG_W         = $clog2(NUM_SEGMENTS),
  localparam int GPIO_W        = $clog2(NUM_GPIO)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      UPDATE,
  input  logic [SEG_W-1:0]          REQ_SEGMENT,
  input  logic [REP_WIDTH-1:0]      REQ_REP,
  input  logic [7:0]                TRANSITION_MODE,
  input  logic [63:0]               TRANSITION_VALUE,
  input  logic [SYS_TIME_WIDTH-1:0] SYS_TIME,
  input  logic [NUM_GPIO-1:0]       GPIO_IN,
  input  logic                      IDX_WRAP,
  output logic [SEG_W-1:0]          SEGMENT,
  output logic                      SWAP,
  output logic                      BUSY,
  output logic                      STOP,
  output logic                      ERR
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    WAIT_TIME = 2'd2,
    WAIT_GPIO = 2'd3
  } state_e;

  localparam logic [7:0]           MODE_SYNC = 8'h00;
  localparam logic [7:0]           MODE_TIME = 8'h01;
  localparam logic [7:0]           MODE_GPIO = 8'h02;
  localparam logic [REP_WIDTH-1:0] REP_INF   = {REP_WIDTH{1'b1}};

  state_e                    state_q, state_d, req_state_s;
  logic [SEG_W-1:0]          seg_q, seg_d, pseg_q, pseg_d;
  logic [REP_WIDTH-1:0]      cnt_q, cnt_d, prep_q, prep_d;
  logic [SYS_TIME_WIDTH-1:0] tgt_q, tgt_d;
  logic                      swap_q, swap_d, busy_q, busy_d;
  logic                      stop_q, stop_d, err_q, err_d;
  logic                      mode_ok_s, trig_s, gpio_rise_s;

  // Classify the incoming request: is it acceptable and which wait state does it enter
  always_comb begin
    mode_ok_s   = 1'b0;
    req_state_s = IDLE;
    case (TRANSITION_MODE)
      MODE_SYNC: begin
        mode_ok_s   = 1'b1;
        req_state_s = WAIT_SYNC;
      end
      MODE_TIME: begin
        mode_ok_s   = 1'b1;
        req_state_s = WAIT_TIME;
      end
`ifdef SEGMENT_TRANSITION_GPIO_EN
      MODE_GPIO: begin
        mode_ok_s   = (TRANSITION_VALUE < 64'(NUM_GPIO));
        req_state_s = WAIT_GPIO;
      end
`endif
      default: begin
        mode_ok_s   = 1'b0;
        req_state_s = IDLE;
      end
    endcase
  end

`ifdef SEGMENT_TRANSITION_GPIO_EN
  logic [NUM_GPIO-1:0] sync1_q, sync2_q, prev_q;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= {NUM_GPIO{1'b0}};
      sync2_q <= {NUM_GPIO{1'b0}};
      prev_q  <= {NUM_GPIO{1'b0}};
    end else begin
      sync1_q <= GPIO_IN;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign gpio_rise_s = sync2_q[tgt_q[GPIO_W-1:0]] & ~prev_q[tgt_q[GPIO_W-1:0]];
`else
  logic unused_gpio_s;
  assign unused_gpio_s = ^{GPIO_IN, TRANSITION_VALUE, MODE_GPIO};
  assign gpio_rise_s   = 1'b0;
`endif

  assign trig_s = ((state_q == WAIT_SYNC) && IDX_WRAP) ||
                  ((state_q == WAIT_TIME) && (SYS_TIME >= tgt_q)) ||
                  ((state_q == WAIT_GPIO) && gpio_rise_s);

  // Next-state: a valid UPDATE beats a trigger; repeat counting runs only while idle
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    pseg_d  = pseg_q;
    prep_d  = prep_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    err_d   = err_q;
    swap_d  = 1'b0;
    if (UPDATE && mode_ok_s) begin
      state_d = req_state_s;
      pseg_d  = REQ_SEGMENT;
      prep_d  = REQ_REP;
      tgt_d   = TRANSITION_VALUE[SYS_TIME_WIDTH-1:0];
    end else if (trig_s) begin
      state_d = IDLE;
      seg_d   = pseg_q;
      swap_d  = (pseg_q != seg_q);
      cnt_d   = prep_q;
      stop_d  = 1'b0;
    end else begin
      state_d = state_q;
    end
    if (UPDATE && !mode_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    if ((state_q == IDLE) && IDX_WRAP && (cnt_q != REP_INF)) begin
      if (cnt_q == {REP_WIDTH{1'b0}}) begin
        stop_d = 1'b1;
      end else begin
        cnt_d = cnt_q - REP_WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_d;
    end
    busy_d = (state_d != IDLE);
  end

  // Controller state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      seg_q   <= {SEG_W{1'b0}};
      pseg_q  <= {SEG_W{1'b0}};
      prep_q  <= {REP_WIDTH{1'b0}};
      tgt_q   <= {SYS_TIME_WIDTH{1'b0}};
      cnt_q   <= REP_INF;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      pseg_q  <= pseg_d;
      prep_q  <= prep_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      swap_q  <= swap_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
    end
  end

  assign SEGMENT = seg_q;
  assign SWAP    = swap_q;
  assign BUSY    = busy_q;
  assign STOP    = stop_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Directed self-checking bench for segment_transition_ctrl (default parameters).
module tb_segment_transition_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        UPDATE;
  logic [0:0]  REQ_SEGMENT;
  logic [15:0] REQ_REP;
  logic [7:0]  TRANSITION_MODE;
  logic [63:0] TRANSITION_VALUE;
  logic [55:0] SYS_TIME;
  logic [3:0]  GPIO_IN;
  logic        IDX_WRAP;
  logic [0:0]  SEGMENT;
  logic        SWAP, BUSY, STOP, ERR;

  int checks   = 0;
  int failures = 0;

  segment_transition_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE), .REQ_SEGMENT(REQ_SEGMENT),
    .REQ_REP(REQ_REP), .TRANSITION_MODE(TRANSITION_MODE),
    .TRANSITION_VALUE(TRANSITION_VALUE), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN),
    .IDX_WRAP(IDX_WRAP), .SEGMENT(SEGMENT), .SWAP(SWAP), .BUSY(BUSY),
    .STOP(STOP), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; pulse inputs drop right after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    UPDATE   = 1'b0;
    IDX_WRAP = 1'b0;
  endtask

  task automatic request(input logic [0:0] seg, input logic [15:0] rep,
                         input logic [7:0] mode, input logic [63:0] val);
    UPDATE           = 1'b1;
    REQ_SEGMENT      = seg;
    REQ_REP          = rep;
    TRANSITION_MODE  = mode;
    TRANSITION_VALUE = val;
  endtask

  initial begin
    RST_N = 1'b0; UPDATE = 1'b0; REQ_SEGMENT = 1'b0; REQ_REP = 16'd0;
    TRANSITION_MODE = 8'h00; TRANSITION_VALUE = 64'd0; SYS_TIME = 56'd0;
    GPIO_IN = 4'b0000; IDX_WRAP = 1'b0;
    #1;
    check("rst_seg", SEGMENT, 1'b0);
    check("rst_swap", SWAP, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_stop", STOP, 1'b0);
    check("rst_err", ERR, 1'b0);
    step(); step();
    RST_N = 1'b1;
    step();

    // Sync-index transition, then repeat countdown to STOP
    request(1'b1, 16'd2, 8'h00, 64'd0);
    step();
    check("sync_busy", BUSY, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("sync_wait_seg", SEGMENT, 1'b0);
    check("sync_wait_swap", SWAP, 1'b0);
    IDX_WRAP = 1'b1; step();
    check("sync_swap", SWAP, 1'b1);
    check("sync_seg", SEGMENT, 1'b1);
    check("sync_idle", BUSY, 1'b0);
    step();
    check("sync_swap_pulse", SWAP, 1'b0);
    IDX_WRAP = 1'b1; step();
    check("wrap1_stop", STOP, 1'b0);
    IDX_WRAP = 1'b1; step();
    check("wrap2_stop", STOP, 1'b0);
    IDX_WRAP = 1'b1; step();
    check("wrap3_stop", STOP, 1'b1);
    IDX_WRAP = 1'b1; step();
    check("wrap4_stop_hold", STOP, 1'b1);

    // System-time transition: future target, then past target
    SYS_TIME = 56'd100;
    request(1'b0, 16'd5, 8'h01, 64'd110);
    step();
    check("time_busy", BUSY, 1'b1);
    check("time_stop_kept", STOP, 1'b1);
    SYS_TIME = 56'd105; step();
    check("time_early_swap", SWAP, 1'b0);
    SYS_TIME = 56'd110; step();
    check("time_swap", SWAP, 1'b1);
    check("time_seg", SEGMENT, 1'b0);
    check("time_stop_clr", STOP, 1'b0);
    request(1'b1, 16'd0, 8'h01, 64'd50);
    step();
    check("past_busy", BUSY, 1'b1);
    check("past_swap_early", SWAP, 1'b0);
    step();
    check("past_swap", SWAP, 1'b1);
    check("past_seg", SEGMENT, 1'b1);
    IDX_WRAP = 1'b1; step();
    check("rep0_stop", STOP, 1'b1);

    // Request for the already-active segment: reload without SWAP
    request(1'b1, 16'd3, 8'h01, 64'd0);
    step();
    step();
    check("same_swap", SWAP, 1'b0);
    check("same_seg", SEGMENT, 1'b1);
    check("same_stop_clr", STOP, 1'b0);
    check("same_idle", BUSY, 1'b0);

    // Invalid mode while pending keeps the pending request
    SYS_TIME = 56'd200;
    request(1'b0, 16'd4, 8'h01, 64'd300);
    step();
    request(1'b1, 16'd4, 8'h05, 64'd0);
    step();
    check("bad_err", ERR, 1'b1);
    check("bad_busy", BUSY, 1'b1);
    SYS_TIME = 56'd300; step();
    check("kept_swap", SWAP, 1'b1);
    check("kept_seg", SEGMENT, 1'b0);

    // New UPDATE coincident with time match replaces the old request
    request(1'b1, 16'd4, 8'h01, 64'd400);
    step();
    SYS_TIME = 56'd400;
    request(1'b1, 16'hFFFF, 8'h00, 64'd0);
    step();
    check("coinc_swap", SWAP, 1'b0);
    check("coinc_seg", SEGMENT, 1'b0);
    check("coinc_busy", BUSY, 1'b1);
    step();
    check("coinc_old_gone", SWAP, 1'b0);
    IDX_WRAP = 1'b1; step();
    check("coinc_new_swap", SWAP, 1'b1);
    check("coinc_new_seg", SEGMENT, 1'b1);
    check("err_sticky", ERR, 1'b1);

    // Infinite repeat never stops
    for (int i = 0; i < 1000; i++) begin
      IDX_WRAP = 1'b1; step();
    end
    check("inf_stop", STOP, 1'b0);

    // Asynchronous reset in the middle of a sync wait
    request(1'b0, 16'd1, 8'h00, 64'd0);
    step();
    check("prerst_busy", BUSY, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_seg", SEGMENT, 1'b0);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_err", ERR, 1'b0);
    check("midrst_stop", STOP, 1'b0);
    check("midrst_swap", SWAP, 1'b0);
    step();
    RST_N = 1'b1;
    step();
    IDX_WRAP = 1'b1; step();
    check("postrst_no_swap", SWAP, 1'b0);
    check("postrst_idle", BUSY, 1'b0);

`ifdef SEGMENT_TRANSITION_GPIO_EN
    request(1'b1, 16'hFFFF, 8'h02, 64'd2);
    step();
    check("gpio_busy", BUSY, 1'b1);
    GPIO_IN[1] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("gpio_other_swap", SWAP, 1'b0);
    check("gpio_other_busy", BUSY, 1'b1);
    GPIO_IN[2] = 1'b1;
    step();
    check("gpio_lat1", SWAP, 1'b0);
    step();
    check("gpio_lat2", SWAP, 1'b0);
    step();
    check("gpio_swap", SWAP, 1'b1);
    check("gpio_seg", SEGMENT, 1'b1);
    request(1'b0, 16'd1, 8'h02, 64'd4);
    step();
    check("gpio_badidx_err", ERR, 1'b1);
    check("gpio_badidx_busy", BUSY, 1'b0);
`else
    request(1'b1, 16'd1, 8'h02, 64'd2);
    step();
    check("nogpio_err", ERR, 1'b1);
    check("nogpio_busy", BUSY, 1'b0);
    GPIO_IN = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    check("nogpio_seg", SEGMENT, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_transition_ctrl.md
SEGMENT_TRANSITION_CTRL -- requirements
Module: segment_transition_ctrl

Interface
REQ-001 Parameter NUM_SEGMENTS, default 2, number of selectable segments (>=2); SEG_W = $clog2(NUM_SEGMENTS).
REQ-002 Parameter REP_WIDTH, default 16, width of repeat count.
REQ-003 Parameter SYS_TIME_WIDTH, default 56, width of system-time input.
REQ-004 Parameter NUM_GPIO, default 4, number of GPIO trigger inputs; GPIO_W = $clog2(NUM_GPIO).
REQ-005 CLK  input  1  sole clock, all logic rising-edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 UPDATE  input  1  one-cycle pulse: latch new transition request.
REQ-008 REQ_SEGMENT  input  SEG_W  requested segment.
REQ-009 REQ_REP  input  REP_WIDTH  repeat count for requested segment; all-ones = infinite.
REQ-010 TRANSITION_MODE  input  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO; others invalid.
REQ-011 TRANSITION_VALUE  input  64  SYS_TIME target (low SYS_TIME_WIDTH bits) or GPIO index (low GPIO_W bits).
REQ-012 SYS_TIME  input  SYS_TIME_WIDTH  free-running system time, synchronous to CLK.
REQ-013 GPIO_IN  input  NUM_GPIO  asynchronous external triggers.
REQ-014 IDX_WRAP  input  1  one-cycle pulse when active segment's index wraps from last entry to 0.
REQ-015 SEGMENT  output  SEG_W  active segment, registered.
REQ-016 SWAP  output  1  one-cycle pulse on the cycle SEGMENT changes.
REQ-017 BUSY  output  1  high while a request is pending.
REQ-018 STOP  output  1  high once a finite repeat count is exhausted.
REQ-019 ERR  output  1  sticky: an invalid-mode request was received.

Function
REQ-020 States: IDLE, WAIT_SYNC, WAIT_TIME, WAIT_GPIO; BUSY = (state != IDLE).
REQ-021 On UPDATE with valid mode, latch REQ_SEGMENT/REQ_REP/mode/value; next state WAIT_SYNC/WAIT_TIME/WAIT_GPIO per mode, from any state.
REQ-022 On UPDATE with invalid mode, set ERR, discard request, keep current state and pending request unchanged.
REQ-023 UPDATE while pending replaces the pending request; UPDATE coincident with a trigger: new request wins, old discarded, no SWAP.
REQ-024 WAIT_SYNC fires on IDX_WRAP; WAIT_TIME fires when SYS_TIME >= target (unsigned, evaluated every cycle incl. first WAIT cycle); WAIT_GPIO fires on rising edge of selected GPIO after 2-flop synchronizer (edge detect adds 1 cycle, total 3 cycles CLK latency).
REQ-025 Trigger in cycle N: SEGMENT updated, SWAP=1, repeat counter loaded with latched REP, STOP cleared, state IDLE at N+1.
REQ-026 Request for segment equal to SEGMENT still waits for its trigger, then reloads counter and clears STOP but SWAP stays 0.
REQ-027 In IDLE, each IDX_WRAP decrements repeat counter unless infinite; wrap with counter==0 sets STOP, counter holds 0.
REQ-028 IDX_WRAP on the trigger cycle (SYNC mode or coincident) is consumed by the swap, not counted.
REQ-029 STOP held until next successful trigger; IDX_WRAP ignored for counting while pending; STOP unaffected by pending state.
REQ-030 GPIO index >= NUM_GPIO treated as invalid mode (REQ-022).

Reset
REQ-031 RST_N low asynchronously forces: state IDLE, SEGMENT=0, SWAP=0, BUSY=0, STOP=0, ERR=0, counter all-ones (infinite), synchronizer flops 0.
REQ-032 Reset mid-wait discards pending request; first edge after release behaves as from power-up.

Configuration
REQ-033 Macro SEGMENT_TRANSITION_GPIO_EN defined: GPIO mode, synchronizer and WAIT_GPIO implemented as above.
REQ-034 Macro undefined: no GPIO logic, GPIO_IN unused, mode 0x02 treated as invalid (sets ERR, request discarded).

Verification
REQ-035 Reset, UPDATE seg1 mode 0x00 REP=2; IDX_WRAP after 5 cycles -> SWAP pulse, SEGMENT=1 next cycle; 3 further wraps -> STOP=1 after third.
REQ-036 SYS_TIME=100, UPDATE seg1 mode 0x01 value 110 -> BUSY=1, SWAP on cycle SYS_TIME reaches 110; value 50 -> SWAP one cycle after UPDATE.
REQ-037 GPIO_EN defined, mode 0x02 value 2, raise GPIO_IN[2] -> SWAP exactly 3 cycles later; GPIO_IN[1] edges -> no SWAP.
REQ-038 UPDATE mode 0x05 while WAIT_TIME pending -> ERR=1, pending kept; second valid UPDATE same cycle as time match -> no SWAP, new request pending.
REQ-039 REQ_REP=0xFFFF, 1000 IDX_WRAPs -> STOP stays 0; RST_N low mid WAIT_SYNC -> all outputs 0 immediately, SEGMENT=0.
